// File: rtl/axi_lite_reg_exerciser.sv
// axi_lite_reg_exerciser: AXI4-Lite master that writes a seeded pattern into a bank of slave
// registers, reads it back and reports pass/fail, error count and first failing index.
// Optional per-handshake watchdog: define AXI_LITE_EXERCISER_TIMEOUT_EN.
module axi_lite_reg_exerciser #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned ADDR_STRIDE = 4,
    parameter logic [DATA_WIDTH-1:0] PATTERN_STEP = DATA_WIDTH'(32'h01010101),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      start,
    input  logic                      mode,
    input  logic [DATA_WIDTH-1:0]     seed,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [15:0]               err_count,
    output logic [7:0]                first_fail_idx,
    output logic                      timeout,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    typedef enum logic [2:0] {
        StIdle, StWr, StWresp, StRd, StRdata, StNext, StDone
    } state_t;

    localparam logic [7:0] LastIdx = 8'(NUM_REGS - 1);

    state_t                 state_q;
    logic [7:0]             idx_q;
    logic [DATA_WIDTH-1:0]  seed_q;
    logic                   mode_q;
    logic                   rd_phase_q;  // mode 1 only: 0 = write sweep, 1 = read sweep
    logic                   awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                   busy_q, done_q, pass_q;
    logic [15:0]            err_count_q;
    logic [7:0]             first_fail_idx_q;

    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [DATA_WIDTH-1:0]  cur_data;
    logic                   wr_fin, b_hs, ar_hs, r_hs;
    logic                   b_bad, r_bad, is_last, first_fail;
    logic [15:0]            err_count_inc;

    // Address and pattern follow the current index; both are stable for a whole transaction.
    assign cur_addr = BASE_ADDR + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STRIDE);
    assign cur_data = seed_q + DATA_WIDTH'(idx_q) * PATTERN_STEP;

    // VALIDs are raised on entry to WR, so a low VALID there means that half has completed.
    assign wr_fin = (!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY);
    assign b_hs   = bready_q && M_AXI_BVALID;
    assign ar_hs  = arvalid_q && M_AXI_ARREADY;
    assign r_hs   = rready_q && M_AXI_RVALID;
    assign b_bad  = M_AXI_BRESP != 2'b00;
    assign r_bad  = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != cur_data);

    assign is_last       = idx_q == LastIdx;
    assign first_fail    = err_count_q == 16'd0;
    assign err_count_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

`ifdef AXI_LITE_EXERCISER_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        timeout_q, in_wait, leaving, to_fire;

    assign in_wait = (state_q == StWr) || (state_q == StWresp) ||
                     (state_q == StRd) || (state_q == StRdata);
    assign leaving = ((state_q == StWr) && wr_fin) || ((state_q == StWresp) && b_hs) ||
                     ((state_q == StRd) && ar_hs) || ((state_q == StRdata) && r_hs);
    // A handshake completing in the limit cycle wins over the watchdog.
    assign to_fire = in_wait && !leaving && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;

    // Cycles spent in the current wait state; restarts on every state change.
    always_ff @(posedge ACLK) begin
        if (ARESET || !in_wait || leaving) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end
`else
    // Watchdog compiled out: timeout can never fire, whatever TIMEOUT_CYCLES says.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

    // Test sequencer: state, index, handshake strobes and status, all registered.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q          <= StIdle;
            idx_q            <= '0;
            seed_q           <= '0;
            mode_q           <= 1'b0;
            rd_phase_q       <= 1'b0;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            bready_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_fail_idx_q <= '0;
`ifdef AXI_LITE_EXERCISER_TIMEOUT_EN
            timeout_q        <= 1'b0;
`endif
        end
`ifdef AXI_LITE_EXERCISER_TIMEOUT_EN
        else if (to_fire) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            timeout_q   <= 1'b1;
            err_count_q <= err_count_inc;
            if (first_fail) first_fail_idx_q <= idx_q;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            state_q     <= StDone;
        end
`endif
        else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        seed_q           <= seed;
                        mode_q           <= mode;
                        rd_phase_q       <= 1'b0;
                        idx_q            <= '0;
                        err_count_q      <= '0;
                        first_fail_idx_q <= '0;
`ifdef AXI_LITE_EXERCISER_TIMEOUT_EN
                        timeout_q        <= 1'b0;
`endif
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        awvalid_q        <= 1'b1;
                        wvalid_q         <= 1'b1;
                        state_q          <= StWr;
                    end
                end
                StWr: begin
                    if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (wvalid_q && M_AXI_WREADY) wvalid_q <= 1'b0;
                    if (wr_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= StWresp;
                    end
                end
                StWresp: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (b_bad) begin
                            err_count_q <= err_count_inc;
                            if (first_fail) first_fail_idx_q <= idx_q;
                        end
                        if (!mode_q) begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRd;
                        end else begin
                            state_q <= StNext;
                        end
                    end
                end
                StRd: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    if (r_hs) begin
                        rready_q <= 1'b0;
                        if (r_bad) begin
                            err_count_q <= err_count_inc;
                            if (first_fail) first_fail_idx_q <= idx_q;
                        end
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (is_last && (!mode_q || rd_phase_q)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= first_fail;
                        state_q <= StDone;
                    end else if (is_last) begin
                        // Mode 1: write sweep finished, restart the index for the read sweep.
                        idx_q      <= '0;
                        rd_phase_q <= 1'b1;
                        arvalid_q  <= 1'b1;
                        state_q    <= StRd;
                    end else if (mode_q && rd_phase_q) begin
                        idx_q     <= idx_q + 8'd1;
                        arvalid_q <= 1'b1;
                        state_q   <= StRd;
                    end else begin
                        idx_q     <= idx_q + 8'd1;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= StWr;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_fail_idx = first_fail_idx_q;

    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = cur_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = cur_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
